// File: rtl/sr_latch_ctrl_if.sv
// Write-request handshake between the memory-test logic (master) and
// the SR latch controller (slave).
interface sr_latch_ctrl_if #(
  parameter int AW = 3
) ();

  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_data;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/sr_latch_ctrl.sv
// SR latch bank controller.
// Each accepted write becomes one set or reset pulse of PW cycles on a
// single latch. The pulse is followed by REC quiet cycles and a readback
// of the latch Q, which ends in a one-cycle done/err report.
// Optional feature: define SR_LATCH_CTRL_SKIP_EN to bypass the pulse when
// the latch already holds the requested value.
module sr_latch_ctrl #(
  parameter int AW  = 3,
  parameter int PW  = 2,
  parameter int REC = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  sr_latch_ctrl_if.slave      bus,
  output logic [(2**AW)-1:0]  s_o,
  output logic [(2**AW)-1:0]  r_o,
  input  logic [(2**AW)-1:0]  q_i,
  output logic                done,
  output logic                err
);

  localparam int N    = 2 ** AW;
  localparam int CMAX = (PW > REC) ? PW : REC;
  localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    RECOVER,
    CHECK
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          data_q, data_d;
  logic [N-1:0]  s_d, r_d;
  logic [N-1:0]  sel;
  logic          done_d, err_d;
  logic          ready_q, ready_d;
  logic          run_en;
  logic          accept;

  assign bus.req_ready = ready_q;
  assign accept        = bus.req_valid && ready_q && run_en;

  // Register the release of rst_n once so that the first request is taken on the second edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_en <= 1'b0;
    end else begin
      run_en <= 1'b1;
    end
  end

  // State, counter, captured request and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= 1'b0;
      s_o     <= '0;
      r_o     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      s_o     <= s_d;
      r_o     <= r_d;
      done    <= done_d;
      err     <= err_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic; the drive vectors are derived from the next state so that only PULSE ever drives a latch
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ready_d = 1'b0;
    s_d     = '0;
    r_d     = '0;
    sel     = '0;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          addr_d  = bus.req_addr;
          data_d  = bus.req_data;
          ready_d = 1'b0;
`ifdef SR_LATCH_CTRL_SKIP_EN
          if (q_i[bus.req_addr] == bus.req_data) begin
            state_d = CHECK;
            cnt_d   = '0;
          end else begin
            state_d = PULSE;
            cnt_d   = CW'(PW - 1);
          end
`else
          state_d = PULSE;
          cnt_d   = CW'(PW - 1);
`endif
        end
      end

      PULSE: begin
        if (cnt_q == '0) begin
          if (REC == 0) begin
            state_d = CHECK;
            cnt_d   = '0;
          end else begin
            state_d = RECOVER;
            cnt_d   = CW'(REC - 1);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      RECOVER: begin
        if (cnt_q == '0) begin
          state_d = CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      CHECK: begin
        state_d = IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
        err_d   = (q_i[addr_q] != data_q);
        ready_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        ready_d = 1'b1;
      end
    endcase

    if (state_d == PULSE) begin
      sel = {{(N-1){1'b0}}, 1'b1} << addr_d;
      if (data_d) begin
        s_d = sel;
      end else begin
        r_d = sel;
      end
    end
  end

endmodule

// File: doc/sr_latch_ctrl.md
# sr_latch_ctrl

Synchronous controller that drives a bank of N cross-coupled NOR SR latches from the clocked domain. It accepts single-latch write requests over a valid/ready handshake and converts each into a set or reset pulse of programmable width. It guarantees that no latch ever sees S=R=1, waits a recovery time, then reads back the latch Q and reports completion and mismatch. It sits between the memory-test logic and the raw latch array, whose per-latch s/r inputs and q outputs it owns.

## Interface
- AW, 3, address width; latch count N = 2**AW
- PW, 2, set/reset pulse width in clk cycles, ≥1
- REC, 1, recovery cycles between pulse release and readback, ≥0
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  write request valid
- req_ready  out  1  controller can accept a request
- req_addr  in  AW  target latch index
- req_data  in  1  value to store (1 = set, 0 = reset)
- s_o  out  N  per-latch set drive, to latch s inputs
- r_o  out  N  per-latch reset drive, to latch r inputs
- q_i  in  N  per-latch Q, from latch array, treated as synchronous to clk
- done  out  1  one-cycle completion strobe
- err  out  1  readback mismatch, valid only while done=1

## Operation
- Clock and reset: one clock, `clk`; reset is asynchronous and active-low, `rst_n`.
- All outputs are registered. Reset values are s_o=0, r_o=0, done=0, err=0, req_ready=1, and state IDLE.
- FSM states: IDLE, PULSE, RECOVER, CHECK.
- IDLE: req_ready=1. On req_valid&req_ready, capture addr/data and go to PULSE (see Configuration). Outside IDLE, req_ready=0 and inputs are ignored.
- PULSE: drive only bit addr. If data=1, s_o[addr]=1 and r_o=0. If data=0, r_o[addr]=1 and s_o=0. Hold for exactly PW cycles. Next state is RECOVER, or CHECK if REC=0.
- RECOVER: s_o=r_o=0 for REC cycles, then go to CHECK.
- CHECK: s_o=r_o=0 for one cycle. Sample q_i[addr]. On exit, done←1 for one cycle, err←(q_i[addr]≠data), and the state returns to IDLE.
- Invariants, checked every cycle:
  - s_o & r_o == 0.
  - popcount(s_o|r_o) ≤ 1.
  - s_o/r_o are nonzero only in PULSE.
- Cycle counter is wide enough for max(PW,REC). It reloads on every state entry.
- err is 0 whenever done=0.

## Timing
- Request accepted at rising edge T (the IDLE cycle with req_valid=1).
- The pulse is on s_o/r_o during cycles T+1 … T+PW.
- Recovery occupies cycles T+PW+1 … T+PW+REC.
- CHECK is cycle T+PW+REC+1.
- done/err are high in cycle T+PW+REC+2. req_ready is also 1 in that cycle, so back-to-back requests are accepted there. Throughput is one write per PW+REC+2 cycles.
- rst_n asserted mid-operation: s_o, r_o, done and err clear immediately without waiting for a clock edge. The FSM returns to IDLE, the in-flight request is dropped, and no done is produced.
- rst_n deassertion is synchronized internally; the first request can be accepted on the second rising edge after release.

## Configuration
- SR_LATCH_CTRL_SKIP_EN defined:
  - In IDLE on accept, if q_i[req_addr]==req_data, skip PULSE and RECOVER and go directly to CHECK; done arrives in cycle T+2.
  - Otherwise behaviour is normal.
- Undefined: every accepted request pulses, regardless of current latch state.

## Test plan
- Bench uses AW=3, PW=2, REC=1, with a behavioural NOR-latch model on s_o/r_o→q_i.
- Reset, then write addr=3 data=1 → s_o=8'h08 for 2 cycles, r_o=0; all zero for 2 cycles; done=1, err=0 at T+5; q_i[3]=1.
- Write addr=5 data=0 with the latch preset to 1 → r_o=8'h20 for 2 cycles, s_o=0; done at T+5 with err=0; q_i[5]=0.
- Model latch 2 stuck-at-0, write addr=2 data=1 → done at T+5 with err=1; err=0 on all other cycles.
- req_valid held high with 3 queued requests → req_ready=0 from T+1 to T+4. Requests are accepted at T, T+5 and T+10. s_o&r_o never nonzero, at most one bit active.
- rst_n driven low at T+1 (mid-PULSE) with no clock edge → s_o/r_o drop to 0 at once. After release: no done, req_ready=1, and the next request behaves as in the first scenario.
- SR_LATCH_CTRL_SKIP_EN defined, latch 3 already 1, write addr=3 data=1 → no s_o/r_o activity; done=1, err=0 at T+2.
